// File: rtl/regfile_dump_tx_pkg.sv
// Shared definitions for the register-file dump transmitter.
// State encodings and register-file geometry.
package regfile_dump_tx_pkg;

  localparam int VDP_DATA_W = 16;
  localparam int VDP_NREG   = 4;
  localparam int VDP_RS_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEL     = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SEND_HI = 3'd3,
    ST_SEND_LO = 3'd4
  } dump_state_e;

  function automatic logic [7:0] hi_byte(
    input logic [VDP_DATA_W-1:0] w
  );
    return w[VDP_DATA_W-1 -: 8];
  endfunction

endpackage

// File: rtl/regfile_dump_tx_if.sv
// Regfile read port plus byte-stream link of the dump transmitter.
// The slave side is the transmitter itself.
interface regfile_dump_tx_if;
  import regfile_dump_tx_pkg::*;

  logic                  start;
  logic [VDP_RS_W-1:0]   rs_o;
  logic [VDP_DATA_W-1:0] b_i;
  logic [7:0]            out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, b_i, out_ready,
    output rs_o, out_data, out_valid,
    output busy, done
  );

  modport master (
    output start, b_i, out_ready,
    input  rs_o, out_data, out_valid,
    input  busy, done
  );

endinterface

// File: rtl/regfile_dump_tx.sv
// Walks r0..r(NREG-1), captures each register at its own LOAD
// and streams it out MSB byte first over a valid/ready link.
module regfile_dump_tx
  import regfile_dump_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  regfile_dump_tx_if.slave  bus
);

  dump_state_e           state_q;
  logic [VDP_RS_W-1:0]   idx_q;
  logic [VDP_RS_W-1:0]   idx_d;
  logic [VDP_DATA_W-1:0] shift_q;
  logic [7:0]            data_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  last;

  assign last  = (idx_q == VDP_RS_W'(VDP_NREG - 1));
  assign idx_d = last ? '0 : idx_q + VDP_RS_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_SEL;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SEL: begin
          state_q <= ST_LOAD;
        end
        // Regfile read has had a full cycle to settle on rs_o
        ST_LOAD: begin
          shift_q <= bus.b_i;
          data_q  <= hi_byte(bus.b_i);
          valid_q <= 1'b1;
          state_q <= ST_SEND_HI;
        end
        ST_SEND_HI: begin
          if (bus.out_ready) begin
            data_q  <= shift_q[7:0];
            state_q <= ST_SEND_LO;
          end
        end
        ST_SEND_LO: begin
          if (bus.out_ready) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= idx_d;
            if (last) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SEL;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
          data_q  <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rs_o      = idx_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Directed bench: dump transmitter beside a behavioural 4x16 regfile.
// Covers stream order, stalls, ignored restart, reset mid-dump, snapshots.
module tb_regfile_dump_tx;

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] rf [4];

  int total = 0;
  int bad   = 0;

  logic [7:0] bq [$];
  int done_at, done_cnt, first_v;
  int zero_err, hold_err, busy_err;
  logic [1:0] rs_log [32];

  regfile_dump_tx_if bus ();

  regfile_dump_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.b_i = rf[bus.rs_o];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    rf[0] = 16'hAAAA;
    rf[1] = 16'hBBBB;
    rf[2] = 16'hCCCC;
    rf[3] = 16'hDDDD;
  endtask

  // Stimulus driver: runs one dump and records what the link saw.
  task automatic drive_dump(
    input int stall_k, input int stall_n,
    input int restart_k,
    input int wr_k, input int wr_a,
    input logic [15:0] wr_v
  );
    logic [7:0] pd;
    logic pv, pr;
    bq.delete();
    done_at = -1; done_cnt = 0; first_v = -1;
    zero_err = 0; hold_err = 0; busy_err = 0;
    pv = 1'b0; pd = 8'h00; pr = 1'b1;
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0;
    rs_log[0] = bus.rs_o;
    for (int k = 1; k <= 26; k++) begin
      int j;
      j = k - 1;
      bus.out_ready = !(j >= stall_k && j < stall_k + stall_n);
      bus.start = (j == restart_k);
      if (j == wr_k) rf[wr_a] = wr_v;
      if (bus.out_valid && first_v < 0) first_v = j;
      if (!bus.out_valid && bus.out_data != 8'h00) zero_err++;
      if (pv && !pr && (!bus.out_valid || bus.out_data != pd))
        hold_err++;
      if (done_at < 0 && !bus.busy) busy_err++;
      if (bus.out_valid && bus.out_ready) bq.push_back(bus.out_data);
      pv = bus.out_valid;
      pd = bus.out_data;
      pr = bus.out_ready;
      step();
      rs_log[k] = bus.rs_o;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
        if (bus.busy) busy_err++;
      end
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b want=0", bus.out_valid);
    end
    total++;
    if (bus.out_data !== 8'h00) begin
      bad++; $display("FAIL rst_data got=%h want=00", bus.out_data);
    end
    total++;
    if (bus.rs_o !== 2'd0) begin
      bad++; $display("FAIL rst_rs got=%0d want=0", bus.rs_o);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy_done got=%b%b want=00", bus.busy, bus.done);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL idle_no_start busy=%b want=0", bus.busy);
    end
  endtask

  task automatic test_stream();
    logic [7:0] exp8 [8];
    exp8 = '{8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hDD, 8'hDD};
    preload();
    drive_dump(-1, 0, -1, -1, 0, 16'h0);
    total++;
    if (bq.size() != 8) begin
      bad++; $display("FAIL stream_count got=%0d want=8", bq.size());
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= bq.size() || bq[i] !== exp8[i]) begin
        bad++;
        $display("FAIL stream_byte%0d got=%h want=%h",
                 i, (i < bq.size()) ? bq[i] : 8'hxx, exp8[i]);
      end
    end
    total++;
    if (first_v != 2) begin
      bad++; $display("FAIL first_valid got=%0d want=2", first_v);
    end
    total++;
    if (done_at != 16 || done_cnt != 1) begin
      bad++;
      $display("FAIL stream_done at=%0d cnt=%0d want at=16 cnt=1",
               done_at, done_cnt);
    end
    total++;
    if (busy_err != 0 || zero_err != 0) begin
      bad++;
      $display("FAIL stream_busy_zero busy_err=%0d zero_err=%0d want 0",
               busy_err, zero_err);
    end
  endtask

  task automatic test_rs_seq();
    int errs;
    errs = 0;
    for (int j = 0; j < 16; j++)
      if (rs_log[j] !== 2'(j / 4)) errs++;
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL rs_seq got %0d wrong slots want 0", errs);
    end
    total++;
    if (rs_log[16] !== 2'd0) begin
      bad++; $display("FAIL rs_after_done got=%0d want=0", rs_log[16]);
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp8 [8];
    exp8 = '{8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hDD, 8'hDD};
    preload();
    drive_dump(3, 3, -1, -1, 0, 16'h0);
    total++;
    if (hold_err != 0) begin
      bad++; $display("FAIL stall_hold got=%0d changes want=0", hold_err);
    end
    total++;
    if (bq.size() != 8) begin
      bad++; $display("FAIL stall_count got=%0d want=8", bq.size());
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= bq.size() || bq[i] !== exp8[i]) begin
        bad++;
        $display("FAIL stall_byte%0d got=%h want=%h",
                 i, (i < bq.size()) ? bq[i] : 8'hxx, exp8[i]);
      end
    end
    total++;
    if (done_at != 19) begin
      bad++; $display("FAIL stall_done got=%0d want=19", done_at);
    end
  endtask

  task automatic test_restart();
    preload();
    drive_dump(-1, 0, 6, -1, 0, 16'h0);
    total++;
    if (bq.size() != 8 || done_cnt != 1 || done_at != 16) begin
      bad++;
      $display("FAIL restart_ignored bytes=%0d done=%0d at=%0d want 8/1/16",
               bq.size(), done_cnt, done_at);
    end
    drive_dump(-1, 0, -1, -1, 0, 16'h0);
    total++;
    if (bq.size() != 8 || bq[0] !== 8'hAA || bq[1] !== 8'hAA) begin
      bad++;
      $display("FAIL restart_from_r0 n=%0d b0=%h b1=%h want 8/AA/AA",
               bq.size(), bq[0], bq[1]);
    end
  endtask

  task automatic test_reset_mid();
    int dn;
    preload();
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 10; k++) step();
    total++;
    if (bus.rs_o !== 2'd2 || bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre_rs got rs=%0d v=%b want rs=2 v=1",
               bus.rs_o, bus.out_valid);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.rs_o !== 2'd0 || bus.out_data !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset got v=%b busy=%b rs=%0d d=%h want 0/0/0/00",
               bus.out_valid, bus.busy, bus.rs_o, bus.out_data);
    end
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done) dn++;
      step();
    end
    total++;
    if (dn != 0) begin
      bad++; $display("FAIL mid_reset_done got=%0d pulses want=0", dn);
    end
    drive_dump(-1, 0, -1, -1, 0, 16'h0);
    total++;
    if (bq.size() != 8 || done_at != 16 || bq[4] !== 8'hCC) begin
      bad++;
      $display("FAIL mid_reset_redump n=%0d at=%0d b4=%h want 8/16/CC",
               bq.size(), done_at, bq[4]);
    end
  endtask

  task automatic test_snapshot();
    preload();
    drive_dump(-1, 0, -1, 2, 3, 16'h1234);
    total++;
    if (bq.size() != 8 || bq[6] !== 8'h12 || bq[7] !== 8'h34) begin
      bad++;
      $display("FAIL snap_r3 n=%0d b6=%h b7=%h want 8/12/34",
               bq.size(), bq[6], bq[7]);
    end
    drive_dump(-1, 0, -1, 14, 0, 16'h5555);
    total++;
    if (bq.size() != 8 || bq[0] !== 8'hAA || bq[1] !== 8'hAA ||
        bq[6] !== 8'h12) begin
      bad++;
      $display("FAIL snap_r0_late b0=%h b1=%h b6=%h want AA/AA/12",
               bq[0], bq[1], bq[6]);
    end
    drive_dump(-1, 0, -1, -1, 0, 16'h0);
    total++;
    if (bq[0] !== 8'h55 || bq[1] !== 8'h55) begin
      bad++;
      $display("FAIL snap_r0_next b0=%h b1=%h want 55/55", bq[0], bq[1]);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    preload();
    test_reset();
    test_stream();
    test_rs_seq();
    test_stall();
    test_restart();
    test_reset_mid();
    test_snapshot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
